// File: rtl/noc_ingress_buffer.sv
// Per-channel ingress FIFOs between a NoC router and its network adapter.
// Define OPTIMSOC_NOC_INBUF_STORE_FWD_EN to hold flits until a whole packet (or a full FIFO) is buffered.
module noc_ingress_buffer #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [CHANNELS-1:0]                  in_last,
  input  logic [CHANNELS-1:0]                  in_valid,
  output logic [CHANNELS-1:0]                  in_ready,
  output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
  output logic [CHANNELS-1:0]                  out_last,
  output logic [CHANNELS-1:0]                  out_valid,
  input  logic [CHANNELS-1:0]                  out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    logic [FLIT_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]       wrPtr_q, wrPtr_d;
    logic [AW-1:0]       rdPtr_q, rdPtr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                push, pop;

    // Ready comes only from the registered count, so out_ready never reaches in_ready.
    assign in_ready[c] = (count_q < FULL);
    assign push        = in_valid[c] & in_ready[c] & ~rst;
    assign pop         = out_valid[c] & out_ready[c] & ~rst;
    assign out_flit[c] = mem_q[rdPtr_q][FLIT_WIDTH-1:0];
    assign out_last[c] = mem_q[rdPtr_q][FLIT_WIDTH];

    always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
      end
    end

    // Storage is deliberately left unreset; pointers and count define what is live.
    always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= {in_last[c], in_flit[c]};
    end

`ifdef OPTIMSOC_NOC_INBUF_STORE_FWD_EN
    logic [CW-1:0] pktCnt_q, pktCnt_d;
    logic          pushLast, popLast;

    assign pushLast = push & in_last[c];
    assign popLast  = pop & out_last[c];

    always_comb begin
      pktCnt_d = pktCnt_q;
      if (pushLast && !popLast)      pktCnt_d = pktCnt_q + CW'(1);
      else if (popLast && !pushLast) pktCnt_d = pktCnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) pktCnt_q <= '0;
      else     pktCnt_q <= pktCnt_d;
    end

    // A full FIFO releases regardless, so packets longer than DEPTH cut through instead of deadlocking.
    assign out_valid[c] = (count_q != '0) && ((pktCnt_q != '0) || (count_q == FULL));
`else
    assign out_valid[c] = (count_q != '0);
`endif
  end

endmodule
